// File: rtl/ex_issue_stage.sv
// ex_issue_stage
//
// ID/EX pipeline register and ALU operand issue for the pipelined RISC-V core.
// Decodes opcode/funct3/funct7 in ID into a 3-bit ALU select, registers the
// decoded instruction into EX, and drives the ALU operands. Supports stall
// (hold) and flush (bubble) from the hazard unit.
//
// Optional feature macro: EX_FORWARD_EN
//   defined   - EX operands are forwarded from EX/MEM and MEM/WB (MEM first).
//   undefined - operands come only from latched regfile data / immediate;
//               mem_* and wb_* inputs are ignored.
//
// Ports:
//   clk_i, rst_i                   clock, asynchronous active-low reset
//   id_valid_i                     ID holds a real instruction
//   id_opcode_i/funct3_i/funct7_i  instruction encoding fields
//   id_rs1_i, id_rs2_i, id_rd_i    register indices
//   id_rs1_data_i, id_rs2_data_i   register-file read data
//   id_imm12_i                     raw I-type immediate
//   stall_i, flush_i               hazard control (flush wins over stall)
//   mem_regwrite_i/rd_i/result_i   EX/MEM writeback candidate
//   wb_regwrite_i/rd_i/result_i    MEM/WB writeback candidate
//   ALU_i_1, ALU_i_2               ALU operands (0 for a bubble)
//   ALU_sel_o                      ALU select
//   ex_valid_o, ex_regwrite_o,
//   ex_rd_o                        EX tags passed downstream
//   ex_illegal_o                   latched instruction is unsupported

module ex_issue_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        id_valid_i,
    input  logic [6:0]  id_opcode_i,
    input  logic [2:0]  id_funct3_i,
    input  logic [6:0]  id_funct7_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic [4:0]  id_rd_i,
    input  logic [31:0] id_rs1_data_i,
    input  logic [31:0] id_rs2_data_i,
    input  logic [11:0] id_imm12_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        mem_regwrite_i,
    input  logic [4:0]  mem_rd_i,
    input  logic [31:0] mem_result_i,
    input  logic        wb_regwrite_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_result_i,
    output logic [31:0] ALU_i_1,
    output logic [31:0] ALU_i_2,
    output logic [2:0]  ALU_sel_o,
    output logic        ex_valid_o,
    output logic        ex_regwrite_o,
    output logic [4:0]  ex_rd_o,
    output logic        ex_illegal_o
);

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_AND  = 3'b001,
        ALU_XOR  = 3'b010,
        ALU_SLL  = 3'b011,
        ALU_SUB  = 3'b100,
        ALU_MUL  = 3'b101,
        ALU_SRAI = 3'b110
    } alu_sel_e;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic [4:0]  rd;
        alu_sel_e    sel;
        logic        illegal;
        logic        use_imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rs1_data;
        logic [31:0] op2;
    } ex_reg_t;

    ex_reg_t  ex_q;
    ex_reg_t  id_pkt;
    alu_sel_e dec_sel;
    logic     dec_legal;
    logic     dec_use_imm;
    logic [31:0] dec_op2;

    // ID-side decode
    always_comb begin
        dec_sel     = ALU_ADD;
        dec_legal   = 1'b0;
        dec_use_imm = 1'b0;
        dec_op2     = id_rs2_data_i;
        case (id_opcode_i)
            OP_RTYPE: begin
                case ({id_funct7_i, id_funct3_i})
                    10'b0000000_000: begin dec_sel = ALU_ADD; dec_legal = 1'b1; end
                    10'b0100000_000: begin dec_sel = ALU_SUB; dec_legal = 1'b1; end
                    10'b0000001_000: begin dec_sel = ALU_MUL; dec_legal = 1'b1; end
                    10'b0000000_111: begin dec_sel = ALU_AND; dec_legal = 1'b1; end
                    10'b0000000_100: begin dec_sel = ALU_XOR; dec_legal = 1'b1; end
                    10'b0000000_001: begin dec_sel = ALU_SLL; dec_legal = 1'b1; end
                    default: ;
                endcase
            end
            OP_ITYPE: begin
                if (id_funct3_i == 3'b000) begin
                    dec_sel     = ALU_ADD;
                    dec_legal   = 1'b1;
                    dec_use_imm = 1'b1;
                    dec_op2     = {{20{id_imm12_i[11]}}, id_imm12_i};
                end else if (id_funct3_i == 3'b101 && id_imm12_i[11:5] == 7'b0100000) begin
                    dec_sel     = ALU_SRAI;
                    dec_legal   = 1'b1;
                    dec_use_imm = 1'b1;
                    dec_op2     = {27'b0, id_imm12_i[4:0]};
                end
            end
            default: ;
        endcase
    end

    // Packet loaded from ID; an invalid ID slot becomes a bubble
    always_comb begin
        id_pkt = '0;
        if (id_valid_i) begin
            id_pkt.valid    = 1'b1;
            id_pkt.regwrite = dec_legal;
            id_pkt.rd       = id_rd_i;
            id_pkt.sel      = dec_legal ? dec_sel : ALU_ADD;
            id_pkt.illegal  = ~dec_legal;
            id_pkt.use_imm  = dec_use_imm;
            id_pkt.rs1      = id_rs1_i;
            id_pkt.rs2      = id_rs2_i;
            id_pkt.rs1_data = id_rs1_data_i;
            id_pkt.op2      = dec_op2;
        end
    end

    // ID/EX register: flush > stall > load
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_q <= '0;
        end else if (flush_i) begin
            ex_q <= '0;
        end else if (!stall_i) begin
            ex_q <= id_pkt;
        end
    end

    // EX operand selection
    always_comb begin
        ALU_i_1 = ex_q.rs1_data;
        ALU_i_2 = ex_q.op2;
`ifdef EX_FORWARD_EN
        // Only legal instructions have meaningful source registers to forward.
        if (ex_q.valid && !ex_q.illegal) begin
            if (ex_q.rs1 != '0 && mem_regwrite_i && mem_rd_i == ex_q.rs1) begin
                ALU_i_1 = mem_result_i;
            end else if (ex_q.rs1 != '0 && wb_regwrite_i && wb_rd_i == ex_q.rs1) begin
                ALU_i_1 = wb_result_i;
            end
            if (!ex_q.use_imm) begin
                if (ex_q.rs2 != '0 && mem_regwrite_i && mem_rd_i == ex_q.rs2) begin
                    ALU_i_2 = mem_result_i;
                end else if (ex_q.rs2 != '0 && wb_regwrite_i && wb_rd_i == ex_q.rs2) begin
                    ALU_i_2 = wb_result_i;
                end
            end
        end
`endif
        if (!ex_q.valid) begin
            ALU_i_1 = '0;
            ALU_i_2 = '0;
        end
    end

`ifndef EX_FORWARD_EN
    logic unused_fwd;
    assign unused_fwd = ^{mem_regwrite_i, mem_rd_i, mem_result_i,
                          wb_regwrite_i, wb_rd_i, wb_result_i,
                          ex_q.rs1, ex_q.rs2};
`endif

    assign ALU_sel_o     = ex_q.sel;
    assign ex_valid_o    = ex_q.valid;
    assign ex_regwrite_o = ex_q.regwrite;
    assign ex_rd_o       = ex_q.rd;
    assign ex_illegal_o  = ex_q.illegal;

endmodule

// File: tb/tb_ex_issue_stage.sv
module tb_ex_issue_stage;

`ifdef EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        id_valid_i;
    logic [6:0]  id_opcode_i;
    logic [2:0]  id_funct3_i;
    logic [6:0]  id_funct7_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic [31:0] id_rs1_data_i, id_rs2_data_i;
    logic [11:0] id_imm12_i;
    logic        stall_i, flush_i;
    logic        mem_regwrite_i, wb_regwrite_i;
    logic [4:0]  mem_rd_i, wb_rd_i;
    logic [31:0] mem_result_i, wb_result_i;
    logic [31:0] ALU_i_1, ALU_i_2;
    logic [2:0]  ALU_sel_o;
    logic        ex_valid_o, ex_regwrite_o, ex_illegal_o;
    logic [4:0]  ex_rd_o;

    ex_issue_stage dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_valid_i(id_valid_i), .id_opcode_i(id_opcode_i),
        .id_funct3_i(id_funct3_i), .id_funct7_i(id_funct7_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
        .id_imm12_i(id_imm12_i), .stall_i(stall_i), .flush_i(flush_i),
        .mem_regwrite_i(mem_regwrite_i), .mem_rd_i(mem_rd_i), .mem_result_i(mem_result_i),
        .wb_regwrite_i(wb_regwrite_i), .wb_rd_i(wb_rd_i), .wb_result_i(wb_result_i),
        .ALU_i_1(ALU_i_1), .ALU_i_2(ALU_i_2), .ALU_sel_o(ALU_sel_o),
        .ex_valid_o(ex_valid_o), .ex_regwrite_o(ex_regwrite_o),
        .ex_rd_o(ex_rd_o), .ex_illegal_o(ex_illegal_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        valid;
        logic        regwrite;
        logic [4:0]  rd;
        logic [2:0]  sel;
        logic        illegal;
        logic [31:0] op1;
        logic [31:0] op2;
        bit          chk_data;
    } exp_t;

    exp_t sb[$];
    int unsigned tests  = 0;
    int unsigned failed = 0;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    function automatic exp_t mk(input logic v, input logic rw, input logic [4:0] rd,
                                input logic [2:0] sel, input logic ill,
                                input logic [31:0] o1, input logic [31:0] o2, input bit cd);
        exp_t e;
        e.valid = v; e.regwrite = rw; e.rd = rd; e.sel = sel; e.illegal = ill;
        e.op1 = o1; e.op2 = o2; e.chk_data = cd;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [6:0] f7,
                         input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [11:0] imm);
        id_valid_i = v; id_opcode_i = op; id_funct7_i = f7; id_funct3_i = f3;
        id_rs1_i = r1; id_rs2_i = r2; id_rd_i = rd;
        id_rs1_data_i = d1; id_rs2_data_i = d2; id_imm12_i = imm;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".valid"}, {31'b0, ex_valid_o}, 32'd0);
        chk({tag, ".regwrite"}, {31'b0, ex_regwrite_o}, 32'd0);
        chk({tag, ".rd"}, {27'b0, ex_rd_o}, 32'd0);
        chk({tag, ".sel"}, {29'b0, ALU_sel_o}, 32'd0);
        chk({tag, ".illegal"}, {31'b0, ex_illegal_o}, 32'd0);
        chk({tag, ".op1"}, ALU_i_1, 32'd0);
        chk({tag, ".op2"}, ALU_i_2, 32'd0);
    endtask

    task automatic check_next(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            failed++;
            $error("FAIL %s: observed empty scoreboard expected pending entry", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".valid"}, {31'b0, ex_valid_o}, {31'b0, e.valid});
        chk({tag, ".regwrite"}, {31'b0, ex_regwrite_o}, {31'b0, e.regwrite});
        chk({tag, ".sel"}, {29'b0, ALU_sel_o}, {29'b0, e.sel});
        chk({tag, ".illegal"}, {31'b0, ex_illegal_o}, {31'b0, e.illegal});
        if (e.chk_data) begin
            chk({tag, ".rd"}, {27'b0, ex_rd_o}, {27'b0, e.rd});
            chk({tag, ".op1"}, ALU_i_1, e.op1);
            chk({tag, ".op2"}, ALU_i_2, e.op2);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0]  f7s  [5] = '{7'b0100000, 7'b0000001, 7'b0000000, 7'b0000000, 7'b0000000};
        logic [2:0]  f3s  [5] = '{3'b000, 3'b000, 3'b111, 3'b100, 3'b001};
        logic [2:0]  sels [5] = '{3'b100, 3'b101, 3'b001, 3'b010, 3'b011};
        exp_t ea;

        rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        mem_regwrite_i = 1'b0; mem_rd_i = '0; mem_result_i = '0;
        wb_regwrite_i = 1'b0; wb_rd_i = '0; wb_result_i = '0;
        drive(1'b1, OP_R, 7'b0, 3'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 12'd0);
        tick; tick;
        check_all_zero("reset_hold");

        // Load something, then assert reset mid-cycle: outputs clear at once
        rst_i = 1'b1;
        drive(1'b1, OP_R, 7'b0, 3'b0, 5'd1, 5'd2, 5'd9, 32'd11, 32'd13, 12'd0);
        tick;
        chk("pre_reset.valid", {31'b0, ex_valid_o}, 32'd1);
        #2 rst_i = 1'b0;
        #1 check_all_zero("reset_async");
        #1 rst_i = 1'b1;

        // add x3 = x1 + x2
        drive(1'b1, OP_R, 7'b0, 3'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 12'd0);
        sb.push_back(mk(1'b1, 1'b1, 5'd3, 3'b000, 1'b0, 32'd5, 32'd7, 1'b1));
        tick; check_next("add");

        // R-type decode sweep
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, OP_R, f7s[i], f3s[i], 5'd1, 5'd2, 5'(i + 5),
                  32'(i * 3 + 10), 32'(i + 100), 12'd0);
            sb.push_back(mk(1'b1, 1'b1, 5'(i + 5), sels[i], 1'b0,
                            32'(i * 3 + 10), 32'(i + 100), 1'b1));
            tick; check_next("rsweep");
        end

        // addi with negative immediate
        drive(1'b1, OP_I, 7'b0, 3'b000, 5'd1, 5'd7, 5'd10, 32'd9, 32'h1234, 12'hFFF);
        sb.push_back(mk(1'b1, 1'b1, 5'd10, 3'b000, 1'b0, 32'd9, 32'hFFFFFFFF, 1'b1));
        tick; check_next("addi");

        // srai
        drive(1'b1, OP_I, 7'b0, 3'b101, 5'd1, 5'd5, 5'd11, 32'h80000000, 32'h1234, 12'h405);
        sb.push_back(mk(1'b1, 1'b1, 5'd11, 3'b110, 1'b0, 32'h80000000, 32'd5, 1'b1));
        tick; check_next("srai");

        // srai-like encoding with wrong imm[11:5] is illegal
        drive(1'b1, OP_I, 7'b0, 3'b101, 5'd1, 5'd5, 5'd11, 32'd1, 32'd2, 12'h005);
        sb.push_back(mk(1'b1, 1'b0, 5'd0, 3'b000, 1'b1, 32'd0, 32'd0, 1'b0));
        tick; check_next("srli_illegal");

        // load opcode unsupported
        drive(1'b1, 7'b0000011, 7'b0, 3'b010, 5'd1, 5'd2, 5'd12, 32'd1, 32'd2, 12'd4);
        sb.push_back(mk(1'b1, 1'b0, 5'd0, 3'b000, 1'b1, 32'd0, 32'd0, 1'b0));
        tick; check_next("illegal_op");

        // invalid ID slot -> bubble
        drive(1'b0, OP_R, 7'b0, 3'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 12'd0);
        sb.push_back(mk(1'b0, 1'b0, 5'd0, 3'b000, 1'b0, 32'd0, 32'd0, 1'b1));
        tick; check_next("id_invalid");

        // Forwarding: rs1 = x4 (data 1), rs2 = x6 (data 2)
        mem_regwrite_i = 1'b1; mem_rd_i = 5'd4; mem_result_i = 32'hAA;
        wb_regwrite_i  = 1'b1; wb_rd_i  = 5'd4; wb_result_i  = 32'hBB;
        drive(1'b1, OP_R, 7'b0, 3'b0, 5'd4, 5'd6, 5'd8, 32'd1, 32'd2, 12'd0);
        sb.push_back(mk(1'b1, 1'b1, 5'd8, 3'b000, 1'b0, FWD ? 32'hAA : 32'd1, 32'd2, 1'b1));
        tick; check_next("fwd_mem_over_wb");
        stall_i = 1'b1;
        drive(1'b1, OP_R, 7'b0100000, 3'b0, 5'd9, 5'd9, 5'd9, 32'd99, 32'd99, 12'd0);
        mem_regwrite_i = 1'b0;
        #1 chk("fwd_wb.op1", ALU_i_1, FWD ? 32'hBB : 32'd1);
        wb_rd_i = 5'd6;
        #1 chk("fwd_wb_rs2.op2", ALU_i_2, FWD ? 32'hBB : 32'd2);
        chk("fwd_wb_rs2.op1", ALU_i_1, 32'd1);
        stall_i = 1'b0;

        // x0 is never forwarded
        mem_regwrite_i = 1'b1; mem_rd_i = 5'd0; mem_result_i = 32'hAA;
        wb_regwrite_i = 1'b1; wb_rd_i = 5'd0;
        drive(1'b1, OP_R, 7'b0, 3'b0, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 12'd0);
        sb.push_back(mk(1'b1, 1'b1, 5'd8, 3'b000, 1'b0, 32'd0, 32'd0, 1'b1));
        tick; check_next("fwd_x0");

        // I-type operand 2 is never forwarded even if rs2 field matches
        mem_rd_i = 5'd7; wb_regwrite_i = 1'b0;
        drive(1'b1, OP_I, 7'b0, 3'b000, 5'd3, 5'd7, 5'd8, 32'd4, 32'd0, 12'd16);
        sb.push_back(mk(1'b1, 1'b1, 5'd8, 3'b000, 1'b0, 32'd4, 32'd16, 1'b1));
        tick; check_next("itype_no_fwd");
        mem_regwrite_i = 1'b0;

        // Stall: hold A for 3 cycles while ID changes
        drive(1'b1, OP_R, 7'b0100000, 3'b0, 5'd1, 5'd2, 5'd9, 32'd11, 32'd22, 12'd0);
        ea = mk(1'b1, 1'b1, 5'd9, 3'b100, 1'b0, 32'd11, 32'd22, 1'b1);
        sb.push_back(ea);
        tick; check_next("stall_load");
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, OP_R, 7'b0000001, 3'b0, 5'd1, 5'd2, 5'(20 + i),
                  32'(200 + i), 32'(300 + i), 12'd0);
            sb.push_back(ea);
            tick; check_next("stall_hold");
        end
        stall_i = 1'b0;
        drive(1'b1, OP_R, 7'b0000000, 3'b111, 5'd1, 5'd2, 5'd14, 32'h0F0F, 32'h00FF, 12'd0);
        sb.push_back(mk(1'b1, 1'b1, 5'd14, 3'b001, 1'b0, 32'h0F0F, 32'h00FF, 1'b1));
        tick; check_next("stall_release");

        // Flush beats stall; bubble operands stay zero despite matching mem_rd
        drive(1'b1, OP_R, 7'b0, 3'b0, 5'd4, 5'd4, 5'd15, 32'd3, 32'd3, 12'd0);
        sb.push_back(mk(1'b1, 1'b1, 5'd15, 3'b000, 1'b0, 32'd3, 32'd3, 1'b1));
        tick; check_next("pre_flush");
        stall_i = 1'b1; flush_i = 1'b1;
        mem_regwrite_i = 1'b1; mem_rd_i = 5'd4; mem_result_i = 32'hCC;
        sb.push_back(mk(1'b0, 1'b0, 5'd0, 3'b000, 1'b0, 32'd0, 32'd0, 1'b1));
        tick; check_next("flush");
        stall_i = 1'b0; flush_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
